// File: rtl/serial_word_rx_if.sv
// Signal bundle for serial_word_rx: serial bit input, buffered word output
// with valid/ready handshake, and status pulses.
interface serial_word_rx_if #(
    parameter int W = 7
);
    logic         bit_in;
    logic         bit_valid;
    logic         out_ready;
    logic [W-1:0] x;
    logic         x_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    // Receiver side
    modport slave (
        input  bit_in, bit_valid, out_ready,
        output x, x_valid, busy, frame_err, overrun
    );

    // Bit source / word consumer side
    modport master (
        output bit_in, bit_valid, out_ready,
        input  x, x_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_word_rx.sv
// Framed serial-to-parallel receiver (start, W data bits LSB first, stop)
// with a single-entry output buffer and frame-error / overrun pulses.
module serial_word_rx #(
    parameter int W          = 7,
    parameter bit CHECK_STOP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_word_rx_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(W - 1);

    state_t       state_reg, state_next;
    logic [2:0]   cnt_reg, cnt_next;
    logic [W-1:0] shift_reg, shift_next;
    logic [W-1:0] x_reg, x_next;
    logic         x_valid_reg, x_valid_next;
    logic         frame_err_reg, frame_err_next;
    logic         overrun_reg, overrun_next;
    logic         load;
    logic         transfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            x_reg         <= '0;
            x_valid_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            x_reg         <= x_next;
            x_valid_reg   <= x_valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        load           = 1'b0;
        frame_err_next = 1'b0;

        if (bus.bit_valid) begin
            case (state_reg)
                IDLE: begin
                    if (!bus.bit_in) begin
                        state_next = DATA;
                        cnt_next   = '0;
                    end
                end
                DATA: begin
                    // Shift in from the top so the first data bit lands in bit 0.
                    shift_next = {bus.bit_in, shift_reg[W-1:1]};
                    cnt_next   = cnt_reg + 3'd1;
                    if (cnt_reg == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
                STOP: begin
                    // A zero stop bit is not taken as the next start bit.
                    state_next = IDLE;
                    if (bus.bit_in || !CHECK_STOP) begin
                        load = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        transfer     = x_valid_reg && bus.out_ready;
        x_next       = load ? shift_reg : x_reg;
        x_valid_next = load ? 1'b1 : (transfer ? 1'b0 : x_valid_reg);
        overrun_next = load && x_valid_reg && !bus.out_ready;
    end

    assign bus.x         = x_reg;
    assign bus.x_valid   = x_valid_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.frame_err = frame_err_reg;
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: one receiver checking the stop bit and
// one accepting any stop bit, both fed the same serial stream.
module tb_serial_word_rx;
    localparam int W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic bit_in = 1'b1;
    logic bit_valid = 1'b0;
    logic out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_word_rx_if #(.W(W)) ifa ();
    serial_word_rx_if #(.W(W)) ifb ();

    assign ifa.bit_in    = bit_in;
    assign ifa.bit_valid = bit_valid;
    assign ifa.out_ready = out_ready;
    assign ifb.bit_in    = bit_in;
    assign ifb.bit_valid = bit_valid;
    assign ifb.out_ready = out_ready;

    serial_word_rx #(.W(W), .CHECK_STOP(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    serial_word_rx #(.W(W), .CHECK_STOP(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [6:0] ex, input logic ev,
                           input logic eb, input logic ef, input logic eo);
        check({tag, ".a.x"},         32'(ifa.x),         32'(ex));
        check({tag, ".a.x_valid"},   32'(ifa.x_valid),   32'(ev));
        check({tag, ".a.busy"},      32'(ifa.busy),      32'(eb));
        check({tag, ".a.frame_err"}, 32'(ifa.frame_err), 32'(ef));
        check({tag, ".a.overrun"},   32'(ifa.overrun),   32'(eo));
    endtask

    // Drives one strobed bit at a falling edge, after `gap` idle cycles.
    task automatic send_bit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in    = ~b;
        end
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
    endtask

    // Start bit, data LSB first, stop bit; returns at the stop-strobe cycle.
    task automatic send_frame(input logic [6:0] d, input logic stop, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(d[i], gap);
        send_bit(stop, gap);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    task automatic consume();
        @(negedge clk);
        bit_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check_a("reset", 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        check_a("after_reset", 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bad stop bit: checker discards, non-checker accepts
        send_frame(7'h7F, 1'b0, 0);
        check("badstop.busy_in_stop", 32'(ifa.busy), 32'd1);
        idle_cycle();
        check_a("badstop", 7'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("badstop.b.x",         32'(ifb.x),         32'h7F);
        check("badstop.b.x_valid",   32'(ifb.x_valid),   32'd1);
        check("badstop.b.frame_err", 32'(ifb.frame_err), 32'd0);
        idle_cycle();
        check("badstop.pulse_end", 32'(ifa.frame_err), 32'd0);
        consume();
        check("badstop.b.consumed", 32'(ifb.x_valid), 32'd0);

        // Basic frame, continuous strobes
        send_frame(7'b0011010, 1'b1, 0);
        check("basic.busy_in_stop",    32'(ifa.busy),    32'd1);
        check("basic.xvalid_in_stop",  32'(ifa.x_valid), 32'd0);
        idle_cycle();
        check_a("basic", 7'h1A, 1'b1, 1'b0, 1'b0, 1'b0);
        check("basic.b.x", 32'(ifb.x), 32'h1A);

        // Handshake: one-cycle ready drains, x retained; ready when empty is a no-op
        consume();
        check_a("handshake", 7'h1A, 1'b0, 1'b0, 1'b0, 1'b0);
        consume();
        check_a("ready_empty", 7'h1A, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gapped strobes: FSM must hold on idle cycles
        send_frame(7'b0011010, 1'b1, 2);
        check("gapped.xvalid_in_stop", 32'(ifa.x_valid), 32'd0);
        idle_cycle();
        check_a("gapped", 7'h1A, 1'b1, 1'b0, 1'b0, 1'b0);
        consume();

        // Overrun: two back-to-back words, never consumed
        send_frame(7'h55, 1'b1, 0);
        send_bit(1'b0, 0);
        check("overrun.first_x",      32'(ifa.x),       32'h55);
        check("overrun.first_noovr",  32'(ifa.overrun), 32'd0);
        for (int i = 0; i < W; i++) send_bit(W'(7'h2A) >> i & 1'b1, 0);
        send_bit(1'b1, 0);
        idle_cycle();
        check_a("overrun", 7'h2A, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        check("overrun.pulse_end", 32'(ifa.overrun), 32'd0);
        consume();

        // Simultaneous load and transfer: ready only on the second load edge
        send_frame(7'h55, 1'b1, 0);
        send_frame(7'h2A, 1'b1, 0);
        check("simul.x_before", 32'(ifa.x), 32'h55);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        bit_valid = 1'b0;
        check_a("simul", 7'h2A, 1'b1, 1'b0, 1'b0, 1'b0);
        consume();

        // Reset mid-frame after 4 data bits
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        @(negedge clk);
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_a("midreset", 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(7'h01, 1'b1, 0);
        idle_cycle();
        check_a("after_midreset", 7'h01, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
